// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the CPU datapath.
// The datapath supplies the instruction register and the CON flag; the
// sequencer drives the ALU operation select and every register/RAM strobe.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con_ff;
  logic [4:0]  OpCode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout, MARin, MDRin, MDRout;
  logic        HIin, HIout, LOin, LOout, Cout, CONin, OutportIn, InPortout;
  logic        Read, Write;

  // Sequencer side
  modport master (
    input  ir, con_ff,
    output OpCode,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout, MARin, MDRin, MDRout,
    output HIin, HIout, LOin, LOout, Cout, CONin, OutportIn, InPortout,
    output Read, Write
  );

  // Datapath side
  modport slave (
    output ir, con_ff,
    input  OpCode,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout, MARin, MDRin, MDRout,
    input  HIin, HIout, LOin, LOout, Cout, CONin, OutportIn, InPortout,
    input  Read, Write
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch in T0-T2, decode ir[31:27], execute in
// T3-T7 under a step counter and a run/halt FSM.
// Optional single-step mode is built when CS_SINGLE_STEP_EN is defined: the
// sequencer then parks in PAUSE after each instruction until a step pulse.
// Strobes are decoded combinationally from state, step and ir so that each
// strobe is valid in the very cycle of its step; clr blanks them at once.
module control_sequencer (
  input  logic clk,
  input  logic clr,
  input  logic stop,
`ifdef CS_SINGLE_STEP_EN
  input  logic step,
`endif
  output logic run,
  output logic illegal,
  control_sequencer_if.master bus
);

  localparam logic [4:0] OP_INC = 5'b11111;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;

  // Instruction opcodes (ir[31:27])
  localparam logic [4:0] I_LD   = 5'b00000;
  localparam logic [4:0] I_LDI  = 5'b00001;
  localparam logic [4:0] I_ST   = 5'b00010;
  localparam logic [4:0] I_ADDI = 5'b01011;
  localparam logic [4:0] I_ANDI = 5'b01100;
  localparam logic [4:0] I_ORI  = 5'b01101;
  localparam logic [4:0] I_MUL  = 5'b01110;
  localparam logic [4:0] I_DIV  = 5'b01111;
  localparam logic [4:0] I_NEG  = 5'b10000;
  localparam logic [4:0] I_NOT  = 5'b10001;
  localparam logic [4:0] I_BR   = 5'b10010;
  localparam logic [4:0] I_JR   = 5'b10011;
  localparam logic [4:0] I_IN   = 5'b10101;
  localparam logic [4:0] I_OUT  = 5'b10110;
  localparam logic [4:0] I_MFHI = 5'b10111;
  localparam logic [4:0] I_MFLO = 5'b11000;
  localparam logic [4:0] I_HALT = 5'b11010;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [2:0]  t_reg;
  logic        stop_seen_reg;
  logic        illegal_reg;

  logic [4:0]  op;
  logic [2:0]  last_t;
  logic        is_illegal;
  logic        is_halt;
  logic        stop_now;
  logic        active;
  logic        unused_ir_bits;

  assign op             = bus.ir[31:27];
  assign unused_ir_bits = ^bus.ir[26:0];
  assign is_halt        = (op == I_HALT);
  assign is_illegal     = (op == 5'b10100) || (op >= 5'b11011);
  // A stop seen at any point of the instruction, including this cycle
  assign stop_now       = stop || stop_seen_reg;
  assign active         = !clr && (state_reg == S_RUN);
  assign run            = active;
  assign illegal        = illegal_reg && !clr;

  // Final execute step of the instruction currently in ir
  always_comb begin
    last_t = 3'd3;
    case (op) inside
      I_LD, I_ST:               last_t = 3'd7;
      I_LDI:                    last_t = 3'd5;
      [5'b00011:5'b01010]:      last_t = 3'd5;
      I_ADDI, I_ANDI, I_ORI:    last_t = 3'd5;
      I_MUL, I_DIV:             last_t = 3'd6;
      I_NEG, I_NOT:             last_t = 3'd4;
      I_BR:                     last_t = 3'd6;
      default:                  last_t = 3'd3;
    endcase
  end

  // Run/halt FSM, step counter, pending stop and sticky illegal flag
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= S_RUN;
      t_reg         <= 3'd0;
      stop_seen_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (t_reg == last_t) begin
            // Instruction boundary: decide between next fetch and halting
            t_reg         <= 3'd0;
            stop_seen_reg <= 1'b0;
            if (is_illegal) begin
              illegal_reg <= 1'b1;
              state_reg   <= S_HALT;
            end else if (is_halt || stop_now) begin
              state_reg   <= S_HALT;
            end else begin
`ifdef CS_SINGLE_STEP_EN
              state_reg   <= S_PAUSE;
`else
              state_reg   <= S_RUN;
`endif
            end
          end else begin
            t_reg <= t_reg + 3'd1;
            if (stop) begin
              stop_seen_reg <= 1'b1;
            end
          end
        end
`ifdef CS_SINGLE_STEP_EN
        S_PAUSE: begin
          // Waiting for a step pulse; stop still wins
          if (stop) begin
            state_reg <= S_HALT;
          end else if (step) begin
            state_reg <= S_RUN;
            t_reg     <= 3'd0;
          end
        end
`endif
        default: begin
          state_reg <= S_HALT;
        end
      endcase
    end
  end

  // Strobe decode from state, step and opcode
  always_comb begin
    bus.OpCode    = 5'd0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.BAout     = 1'b0;
    bus.PCin      = 1'b0;
    bus.PCout     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin       = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIin      = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOin      = 1'b0;
    bus.LOout     = 1'b0;
    bus.Cout      = 1'b0;
    bus.CONin     = 1'b0;
    bus.OutportIn = 1'b0;
    bus.InPortout = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    if (active) begin
      case (t_reg)
        3'd0: begin
          bus.PCout  = 1'b1;
          bus.MARin  = 1'b1;
          bus.Zin    = 1'b1;
          bus.OpCode = OP_INC;
        end
        3'd1: begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
        end
        3'd2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        default: begin
          case (op) inside
            // Memory access: address = base + C, shared T3/T4
            I_LD, I_LDI, I_ST: begin
              case (t_reg)
                3'd3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                3'd4: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.OpCode = OP_ADD; end
                3'd5: begin
                  bus.Zlowout = 1'b1;
                  if (op == I_LDI) begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                  end else begin
                    bus.MARin = 1'b1;
                  end
                end
                3'd6: begin
                  if (op == I_ST) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                  end else begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                  end
                end
                default: begin
                  if (op == I_ST) begin
                    bus.Write = 1'b1;
                  end else begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                  end
                end
              endcase
            end
            // Register-register ALU ops pass their own opcode to the ALU
            [5'b00011:5'b01010]: begin
              case (t_reg)
                3'd3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                3'd4: begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.OpCode = op; end
                default: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              endcase
            end
            I_ADDI, I_ANDI, I_ORI: begin
              case (t_reg)
                3'd3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                3'd4: begin
                  bus.Cout = 1'b1;
                  bus.Zin  = 1'b1;
                  if (op == I_ADDI)      bus.OpCode = OP_ADD;
                  else if (op == I_ANDI) bus.OpCode = OP_AND;
                  else                   bus.OpCode = OP_OR;
                end
                default: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              endcase
            end
            // 64-bit result split across LO and HI
            I_MUL, I_DIV: begin
              case (t_reg)
                3'd3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                3'd4: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.OpCode = op; end
                3'd5: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                default: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
              endcase
            end
            I_NEG, I_NOT: begin
              if (t_reg == 3'd3) begin
                bus.Grb    = 1'b1;
                bus.Rout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.OpCode = op;
              end else begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
              end
            end
            // Branch target = PC + C, loaded only when CON is set in T6
            I_BR: begin
              case (t_reg)
                3'd3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                3'd4: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                3'd5: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.OpCode = OP_ADD; end
                default: begin
                  bus.Zlowout = bus.con_ff;
                  bus.PCin    = bus.con_ff;
                end
              endcase
            end
            I_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            I_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            I_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutportIn = 1'b1; end
            I_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            I_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            // nop, halt and undefined opcodes drive nothing in T3
            default: begin
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the stimulus process pushes the
// hand-computed expected output word for every cycle it drives; a monitor
// pops and compares on the falling edge.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;
  logic stop;
  logic run;
  logic illegal;

  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .stop    (stop),
    .run     (run),
    .illegal (illegal),
    .bus     (bus)
  );

  // Strobe bit positions in the observed word
  localparam logic [25:0] B_WRITE  = 26'd1 << 0;
  localparam logic [25:0] B_READ   = 26'd1 << 1;
  localparam logic [25:0] B_INPO   = 26'd1 << 2;
  localparam logic [25:0] B_OUTPI  = 26'd1 << 3;
  localparam logic [25:0] B_CONIN  = 26'd1 << 4;
  localparam logic [25:0] B_COUT   = 26'd1 << 5;
  localparam logic [25:0] B_LOOUT  = 26'd1 << 6;
  localparam logic [25:0] B_LOIN   = 26'd1 << 7;
  localparam logic [25:0] B_HIOUT  = 26'd1 << 8;
  localparam logic [25:0] B_HIIN   = 26'd1 << 9;
  localparam logic [25:0] B_MDROUT = 26'd1 << 10;
  localparam logic [25:0] B_MDRIN  = 26'd1 << 11;
  localparam logic [25:0] B_MARIN  = 26'd1 << 12;
  localparam logic [25:0] B_ZLO    = 26'd1 << 13;
  localparam logic [25:0] B_ZHI    = 26'd1 << 14;
  localparam logic [25:0] B_ZIN    = 26'd1 << 15;
  localparam logic [25:0] B_YIN    = 26'd1 << 16;
  localparam logic [25:0] B_IRIN   = 26'd1 << 17;
  localparam logic [25:0] B_PCOUT  = 26'd1 << 18;
  localparam logic [25:0] B_PCIN   = 26'd1 << 19;
  localparam logic [25:0] B_BAOUT  = 26'd1 << 20;
  localparam logic [25:0] B_ROUT   = 26'd1 << 21;
  localparam logic [25:0] B_RIN    = 26'd1 << 22;
  localparam logic [25:0] B_GRC    = 26'd1 << 23;
  localparam logic [25:0] B_GRB    = 26'd1 << 24;
  localparam logic [25:0] B_GRA    = 26'd1 << 25;

  logic [32:0] obs;
  assign obs = {run, illegal, bus.OpCode,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                bus.PCin, bus.PCout, bus.IRin, bus.Yin, bus.Zin, bus.Zhighout,
                bus.Zlowout, bus.MARin, bus.MDRin, bus.MDRout,
                bus.HIin, bus.HIout, bus.LOin, bus.LOout, bus.Cout, bus.CONin,
                bus.OutportIn, bus.InPortout, bus.Read, bus.Write};

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          fails  = 0;

  function automatic logic [32:0] ex(input logic r, input logic il,
                                     input logic [4:0] opc, input logic [25:0] s);
    return {r, il, opc, s};
  endfunction

  // Drive one cycle and queue what the DUT must show during it
  task automatic cyc(input logic c, input logic st, input logic [32:0] e, input string nm);
    clr  = c;
    stop = st;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic step_exp(input logic [4:0] opc, input logic [25:0] s, input string nm);
    cyc(1'b0, 1'b0, ex(1'b1, 1'b0, opc, s), nm);
  endtask

  task automatic fetch(input string nm);
    step_exp(5'b11111, B_PCOUT | B_MARIN | B_ZIN, {nm, " T0"});
    step_exp(5'd0, B_ZLO | B_PCIN | B_READ | B_MDRIN, {nm, " T1"});
    step_exp(5'd0, B_MDROUT | B_IRIN, {nm, " T2"});
  endtask

  task automatic idle(input int n, input logic il, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, ex(1'b0, il, 5'd0, 26'd0), nm);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", n, obs, e);
      end else begin
        $display("ok   %s: %h", n, obs);
      end
    end
  end

  initial begin
    clr        = 1'b1;
    stop       = 1'b0;
    bus.ir     = 32'h0;
    bus.con_ff = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: everything quiet
    cyc(1'b1, 1'b0, 33'd0, "reset c0");
    cyc(1'b1, 1'b0, 33'd0, "reset c1");

    // add R1,R2,R3
    bus.ir = 32'h18918000;
    fetch("add");
    step_exp(5'd0, B_GRB | B_ROUT | B_YIN, "add T3");
    step_exp(5'b00011, B_GRC | B_ROUT | B_ZIN, "add T4");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "add T5");

    // ld
    bus.ir = 32'h00000000;
    fetch("ld");
    step_exp(5'd0, B_GRB | B_BAOUT | B_YIN, "ld T3");
    step_exp(5'b00011, B_COUT | B_ZIN, "ld T4");
    step_exp(5'd0, B_ZLO | B_MARIN, "ld T5");
    step_exp(5'd0, B_READ | B_MDRIN, "ld T6");
    step_exp(5'd0, B_MDROUT | B_GRA | B_RIN, "ld T7");

    // st
    bus.ir = 32'h10000000;
    fetch("st");
    step_exp(5'd0, B_GRB | B_BAOUT | B_YIN, "st T3");
    step_exp(5'b00011, B_COUT | B_ZIN, "st T4");
    step_exp(5'd0, B_ZLO | B_MARIN, "st T5");
    step_exp(5'd0, B_GRA | B_ROUT | B_MDRIN, "st T6");
    step_exp(5'd0, B_WRITE, "st T7");

    // br not taken
    bus.ir = 32'h90000000;
    bus.con_ff = 1'b0;
    fetch("br0");
    step_exp(5'd0, B_GRA | B_ROUT | B_CONIN, "br0 T3");
    step_exp(5'd0, B_PCOUT | B_YIN, "br0 T4");
    step_exp(5'b00011, B_COUT | B_ZIN, "br0 T5");
    step_exp(5'd0, 26'd0, "br0 T6");

    // br taken
    bus.con_ff = 1'b1;
    fetch("br1");
    step_exp(5'd0, B_GRA | B_ROUT | B_CONIN, "br1 T3");
    step_exp(5'd0, B_PCOUT | B_YIN, "br1 T4");
    step_exp(5'b00011, B_COUT | B_ZIN, "br1 T5");
    step_exp(5'd0, B_ZLO | B_PCIN, "br1 T6");
    bus.con_ff = 1'b0;

    // addi / andi / ori
    bus.ir = 32'h58000000;
    fetch("addi");
    step_exp(5'd0, B_GRB | B_ROUT | B_YIN, "addi T3");
    step_exp(5'b00011, B_COUT | B_ZIN, "addi T4");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "addi T5");
    bus.ir = 32'h60000000;
    fetch("andi");
    step_exp(5'd0, B_GRB | B_ROUT | B_YIN, "andi T3");
    step_exp(5'b01001, B_COUT | B_ZIN, "andi T4");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "andi T5");
    bus.ir = 32'h68000000;
    fetch("ori");
    step_exp(5'd0, B_GRB | B_ROUT | B_YIN, "ori T3");
    step_exp(5'b01010, B_COUT | B_ZIN, "ori T4");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "ori T5");

    // mul
    bus.ir = 32'h70000000;
    fetch("mul");
    step_exp(5'd0, B_GRA | B_ROUT | B_YIN, "mul T3");
    step_exp(5'b01110, B_GRB | B_ROUT | B_ZIN, "mul T4");
    step_exp(5'd0, B_ZLO | B_LOIN, "mul T5");
    step_exp(5'd0, B_ZHI | B_HIIN, "mul T6");

    // neg
    bus.ir = 32'h80000000;
    fetch("neg");
    step_exp(5'b10000, B_GRB | B_ROUT | B_ZIN, "neg T3");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "neg T4");

    // single-step-T3 instructions
    bus.ir = 32'h98000000;
    fetch("jr");
    step_exp(5'd0, B_GRA | B_ROUT | B_PCIN, "jr T3");
    bus.ir = 32'hA8000000;
    fetch("in");
    step_exp(5'd0, B_INPO | B_GRA | B_RIN, "in T3");
    bus.ir = 32'hB0000000;
    fetch("out");
    step_exp(5'd0, B_GRA | B_ROUT | B_OUTPI, "out T3");
    bus.ir = 32'hB8000000;
    fetch("mfhi");
    step_exp(5'd0, B_HIOUT | B_GRA | B_RIN, "mfhi T3");
    bus.ir = 32'hC0000000;
    fetch("mflo");
    step_exp(5'd0, B_LOOUT | B_GRA | B_RIN, "mflo T3");
    bus.ir = 32'hC8000000;
    fetch("nop");
    step_exp(5'd0, 26'd0, "nop T3");

    // stop pulsed in T4 of add: T5 completes, then halt
    bus.ir = 32'h18918000;
    fetch("stop");
    step_exp(5'd0, B_GRB | B_ROUT | B_YIN, "stop T3");
    cyc(1'b0, 1'b1, ex(1'b1, 1'b0, 5'b00011, B_GRC | B_ROUT | B_ZIN), "stop T4");
    step_exp(5'd0, B_ZLO | B_GRA | B_RIN, "stop T5");
    idle(3, 1'b0, "stop halted");

    // halt instruction
    cyc(1'b1, 1'b0, 33'd0, "clr before halt");
    bus.ir = 32'hD0000000;
    fetch("halt");
    step_exp(5'd0, 26'd0, "halt T3");
    idle(20, 1'b0, "halted");

    // clr restarts, then an undefined opcode
    cyc(1'b1, 1'b0, 33'd0, "clr before illegal");
    bus.ir = 32'hF8000000;
    fetch("ill");
    step_exp(5'd0, 26'd0, "ill T3");
    idle(3, 1'b1, "ill halted");
    cyc(1'b1, 1'b0, 33'd0, "clr clears illegal");

    // clr mid-instruction aborts, then fetch restarts
    bus.ir = 32'h00000000;
    fetch("abort");
    step_exp(5'd0, B_GRB | B_BAOUT | B_YIN, "abort T3");
    cyc(1'b1, 1'b0, 33'd0, "abort clr");
    fetch("restart");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the CPU datapath and drives every datapath control strobe each clock.
- Runs instruction fetch (T0–T2), decodes IR[31:27], and sequences execute steps T3–T7 through a step counter plus a run/halt FSM.
- Consumes the datapath's IR value and CON flip-flop output.

Parameters:
- OP_INC, 5'b11111, ALU code for PC+1 (Y operand ignored).
- OP_ADD, 5'b00011, ALU add code; used for address and branch-target calculation and for addi.
- OP_AND, 5'b01001, ALU AND code; used for andi.
- OP_OR, 5'b01010, ALU OR code; used for ori.

Ports:
- clk  input  1  clock
- clr  input  1  synchronous active-high reset
- ir  input  32  instruction register contents
- con_ff  input  1  CON register output (branch condition)
- stop  input  1  synchronous halt request
- OpCode  output  5  ALU operation select
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select/encode strobes
- PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout, MARin, MDRin, MDRout  output  1 each  register strobes
- HIin, HIout, LOin, LOout, Cout, CONin, OutportIn, InPortout  output  1 each  register/port strobes
- Read, Write  output  1 each  RAM strobes
- run  output  1  1 while sequencing
- illegal  output  1  sticky; set on an undefined opcode

Behaviour:
- State: run/halt FSM (RUN, HALT) plus a 3-bit step counter T0–T7.
- Outputs are a pure decode of state, step and ir. Every strobe not listed for a step is 0.
- OpCode is 0 in every step that does not name an ALU code.
- Reset:
  - clr sampled high: step=T0, state=RUN, illegal=0.
  - While clr is high, all outputs are 0 and run=0.
  - First T0 occurs in the cycle after clr falls.
  - clr mid-instruction aborts that instruction with no further strobes.
- Fetch:
  - T0: PCout MARin Zin, OpCode=OP_INC.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Execute (op = ir[31:27]):
  - ld 00000: T3 Grb BAout Yin; T4 Cout Zin OP_ADD; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout Zin OP_ADD; T5 Zlowout Gra Rin.
  - st 00010: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - R-ALU 00011–01010 (add, sub, shr, shl, ror, rol, and, or): T3 Grb Rout Yin; T4 Grc Rout Zin, OpCode=op; T5 Zlowout Gra Rin.
  - addi 01011 / andi 01100 / ori 01101: T3 Grb Rout Yin; T4 Cout Zin, OpCode=OP_ADD/OP_AND/OP_OR respectively; T5 Zlowout Gra Rin.
  - mul 01110 / div 01111: T3 Gra Rout Yin; T4 Grb Rout Zin, OpCode=op; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10000 / not 10001: T3 Grb Rout Zin, OpCode=op; T4 Zlowout Gra Rin.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin OP_ADD; T6 Zlowout PCin only if con_ff=1 (sampled in T6), otherwise no strobes.
  - jr 10011: T3 Gra Rout PCin.
  - in 10101: T3 InPortout Gra Rin.
  - out 10110: T3 Gra Rout OutportIn.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - nop 11001: no T3 strobes.
  - halt 11010: go to HALT at end of T3.
  - 10100 and 11011–11111: illegal; set illegal=1 and go to HALT at end of T3.
- After an instruction's last listed step, the next cycle is T0. Example latencies: nop 4 cycles, R-ALU 6, ld/st 8, br 7.
- stop:
  - Sampled every cycle; honoured only at instruction boundaries.
  - If stop was seen during an instruction, enter HALT instead of the next T0.
- HALT:
  - run=0, all strobes 0; exited only by clr.
  - illegal holds until clr.
- Simultaneous clr with stop or halt: clr wins.

Optional Feature:
- Macro: CS_SINGLE_STEP_EN.
- Enabled:
  - Adds input step (1 bit).
  - After each completed instruction, the sequencer waits in PAUSE (run=0, strobes 0).
  - A 1-cycle step pulse starts the next T0 on the following cycle.
  - stop and halt still take priority over step.
- Disabled: no step port, no PAUSE state; free-running.

Test Plan:
- clr=1 for 2 cycles then 0 -> all outputs 0 while clr is high; next cycle PCout=MARin=Zin=1, OpCode=5'b11111; then T1 Read=MDRin=PCin=1; then T2 IRin=1.
- ir=0x18918000 (add R1,R2,R3) -> T3 Grb Rout Yin; T4 Grc Rout Zin, OpCode=00011; T5 Zlowout Gra Rin; T0 on cycle 7.
- ir=0x00000000 (ld) -> Read=1 exactly in T1 and T6; Gra Rin in T7; 8 cycles total.
- ir=0x90000000 (br) with con_ff=0 -> PCin never asserted after T1; with con_ff=1 -> Zlowout PCin in T6.
- ir=0xD0000000 (halt) -> run=0 from the cycle after T3, strobes stay 0 for 20 cycles; clr restarts at T0.
- ir=0xF8000000 -> illegal=1, run=0. Separately, stop pulsed in T4 of an R-ALU -> T5 completes, then HALT.
